// File: rtl/l2_arbiter_n.sv
// N-channel arbiter between L1 requesters and one shared L2 port.
// One transaction at a time; the grant and the L2 request stay frozen until L2 responds.
module l2_arbiter_n #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 128,
  parameter bit          RR_MODE = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic                       L2_read,
  output logic                       L2_write,
  output logic [ADDR_W-1:0]          L2_addr,
  output logic [DATA_W-1:0]          L2_wdata,
  input  logic [DATA_W-1:0]          L2_rdata,
  input  logic                       L2_resp,
  output logic [NUM_CH-1:0]          grant,
  output logic                       busy
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                l2_read_q, l2_read_d;
  logic                l2_write_q, l2_write_d;
  logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
  logic [DATA_W-1:0]   l2_wdata_q, l2_wdata_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_CH-1:0]   req;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                win_write;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  int unsigned         cand;
  int unsigned         ptr_next;

  assign req = ch_read | ch_write;

  // Winner search: from index 0 in fixed mode, from the rotating pointer in round-robin mode.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_write = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = RR_MODE ? ((32'(rr_ptr_q) + k) % NUM_CH) : k;
      if (!win_found && req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win_found && (win_idx == IDX_W'(i))) begin
        win_write = ch_write[i];
        win_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        win_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_next = 32'(win_idx) + 1;
    if (ptr_next >= NUM_CH) begin
      ptr_next = 0;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    l2_addr_d  = l2_addr_q;
    l2_wdata_d = l2_wdata_q;
    rr_ptr_d   = rr_ptr_q;

    unique case (state_q)
      StIdle: begin
        grant_d    = '0;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
        if (win_found) begin
          state_d    = StBusy;
          grant_d    = NUM_CH'(1) << win_idx;
          l2_write_d = win_write;
          l2_read_d  = ~win_write;
          l2_addr_d  = win_addr;
          l2_wdata_d = win_wdata;
          if (RR_MODE) begin
            rr_ptr_d = IDX_W'(ptr_next);
          end
        end
      end
      StBusy: begin
        // Channel inputs are ignored here; only L2 completion ends the transaction.
        if (L2_resp) begin
          state_d    = StIdle;
          grant_d    = '0;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        grant_d    = '0;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      l2_addr_q  <= '0;
      l2_wdata_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
      l2_addr_q  <= l2_addr_d;
      l2_wdata_q <= l2_wdata_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Response path is combinational so the owner sees L2 data in the completion cycle.
  always_comb begin
    ch_resp  = '0;
    ch_rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((state_q == StBusy) && grant_q[i] && L2_resp) begin
        ch_resp[i]                    = 1'b1;
        ch_rdata[i*DATA_W +: DATA_W] = L2_rdata;
      end
    end
  end

  assign grant    = grant_q;
  assign busy     = (state_q == StBusy);
  assign L2_read  = l2_read_q;
  assign L2_write = l2_write_q;
  assign L2_addr  = l2_addr_q;
  assign L2_wdata = l2_wdata_q;

endmodule

// File: tb/tb_l2_arbiter_n.sv
// Random-stimulus bench for l2_arbiter_n: a fixed-priority and a round-robin instance share
// inputs and are each compared every cycle against a transaction-level reference model.
module tb_l2_arbiter_n;

  localparam int NCH = 3;
  localparam int AW  = 16;
  localparam int DW  = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    ch_read;
  logic [NCH-1:0]    ch_write;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [DW-1:0]     l2_rdata;
  logic              l2_resp;

  logic [NCH*DW-1:0] ch_rdata [2];
  logic [NCH-1:0]    ch_resp  [2];
  logic [NCH-1:0]    grant    [2];
  logic              l2_read  [2];
  logic              l2_write [2];
  logic              busy     [2];
  logic [AW-1:0]     l2_addr  [2];
  logic [DW-1:0]     l2_wdata [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner index (-1 when idle), latched request, round-robin pointer.
  int            owner [2];
  bit            own_w [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  int            ptr [2];

  always #5 clk = ~clk;

  l2_arbiter_n #(
    .NUM_CH (NCH),
    .ADDR_W (AW),
    .DATA_W (DW),
    .RR_MODE(1'b0)
  ) u_fixed (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_read (ch_read),
    .ch_write(ch_write),
    .ch_addr (ch_addr),
    .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata[0]),
    .ch_resp (ch_resp[0]),
    .L2_read (l2_read[0]),
    .L2_write(l2_write[0]),
    .L2_addr (l2_addr[0]),
    .L2_wdata(l2_wdata[0]),
    .L2_rdata(l2_rdata),
    .L2_resp (l2_resp),
    .grant   (grant[0]),
    .busy    (busy[0])
  );

  l2_arbiter_n #(
    .NUM_CH (NCH),
    .ADDR_W (AW),
    .DATA_W (DW),
    .RR_MODE(1'b1)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_read (ch_read),
    .ch_write(ch_write),
    .ch_addr (ch_addr),
    .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata[1]),
    .ch_resp (ch_resp[1]),
    .L2_read (l2_read[1]),
    .L2_write(l2_write[1]),
    .L2_addr (l2_addr[1]),
    .L2_wdata(l2_wdata[1]),
    .L2_rdata(l2_rdata),
    .L2_resp (l2_resp),
    .grant   (grant[1]),
    .busy    (busy[1])
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      owner[m]   = -1;
      own_w[m]   = 1'b0;
      m_addr[m]  = '0;
      m_wdata[m] = '0;
      ptr[m]     = 0;
    end
  endtask

  task automatic drive_idle();
    ch_read  = '0;
    ch_write = '0;
    ch_addr  = '0;
    ch_wdata = '0;
    l2_rdata = '0;
    l2_resp  = 1'b0;
  endtask

  task automatic drive_random();
    for (int i = 0; i < NCH; i++) begin
      ch_read[i]              = ($urandom_range(0, 2) == 0);
      ch_write[i]             = ($urandom_range(0, 3) == 0);
      ch_addr[i*AW +: AW]     = AW'($urandom);
      ch_wdata[i*DW +: DW]    = {$urandom, $urandom};
    end
    l2_rdata = {$urandom, $urandom};
    l2_resp  = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_outputs();
    logic [NCH-1:0]    e_grant;
    logic [NCH-1:0]    e_resp;
    logic [NCH*DW-1:0] e_rdata;
    bit                act;
    for (int m = 0; m < 2; m++) begin
      act     = (owner[m] >= 0);
      e_grant = '0;
      e_resp  = '0;
      e_rdata = '0;
      if (act) begin
        e_grant[owner[m]] = 1'b1;
        if (l2_resp) begin
          e_resp[owner[m]]            = 1'b1;
          e_rdata[owner[m]*DW +: DW] = l2_rdata;
        end
      end
      check_eq($sformatf("m%0d grant", m), 256'(grant[m]), 256'(e_grant));
      check_eq($sformatf("m%0d busy", m), 256'(busy[m]), 256'(act));
      check_eq($sformatf("m%0d L2_read", m), 256'(l2_read[m]), 256'(act && !own_w[m]));
      check_eq($sformatf("m%0d L2_write", m), 256'(l2_write[m]), 256'(act && own_w[m]));
      check_eq($sformatf("m%0d L2_addr", m), 256'(l2_addr[m]), 256'(m_addr[m]));
      check_eq($sformatf("m%0d L2_wdata", m), 256'(l2_wdata[m]), 256'(m_wdata[m]));
      check_eq($sformatf("m%0d ch_resp", m), 256'(ch_resp[m]), 256'(e_resp));
      check_eq($sformatf("m%0d ch_rdata", m), 256'(ch_rdata[m]), 256'(e_rdata));
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int w;
    int c;
    for (int m = 0; m < 2; m++) begin
      if (owner[m] >= 0) begin
        if (l2_resp) owner[m] = -1;
      end else begin
        w = -1;
        for (int k = 0; k < NCH; k++) begin
          c = (m == 1) ? (ptr[m] + k) % NCH : k;
          if (w < 0 && (ch_read[c] || ch_write[c])) w = c;
        end
        if (w >= 0) begin
          owner[m]   = w;
          own_w[m]   = ch_write[w];
          m_addr[m]  = ch_addr[w*AW +: AW];
          m_wdata[m] = ch_wdata[w*DW +: DW];
          if (m == 1) ptr[m] = (w + 1) % NCH;
        end
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_random();
      #1;
      check_outputs();
      model_step();
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    run_cycles(1500);

    // Let any transaction finish, then start a ch1 read and reset in the middle of it.
    @(negedge clk);
    drive_idle();
    l2_resp = 1'b1;
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
    drive_idle();
    ch_read[1]          = 1'b1;
    ch_addr[1*AW +: AW] = 16'h1234;
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #2;
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("m%0d pre-reset L2_read", m), 256'(l2_read[m]), 256'(1));
      check_eq($sformatf("m%0d pre-reset L2_addr", m), 256'(l2_addr[m]), 256'(16'h1234));
    end
    rst_n = 1'b0;
    drive_idle();
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("m%0d async L2_read", m), 256'(l2_read[m]), 256'(0));
      check_eq($sformatf("m%0d async grant", m), 256'(grant[m]), 256'(0));
    end
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
    model_step();

    run_cycles(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
